// File: rtl/instrmem_loader.sv
// instrmem_loader
//   Loads a program image into instruction memory from a byte stream. Bytes
//   are packed four at a time, little-endian, into 32-bit words. Each word is
//   written to consecutive word addresses. The CPU is held in reset while the
//   load runs. When the load ends, done pulses and the 8-bit checksum of the
//   accepted bytes is available.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start           begin a load (only honoured while idle)
//   base_addr       first byte address (low two bits ignored)
//   len_words       number of words to load, 0 = no writes
//   in_valid/in_data/in_ready   byte stream handshake
//   mem_we/mem_addr/mem_wd      instruction memory write port
//   cpu_hold, busy  high while a load is in progress
//   done            one-cycle completion pulse
//   checksum        sum mod 256 of the bytes accepted in the last load
module instrmem_loader #(
    parameter int A_WIDTH   = 12,
    parameter int D_WIDTH   = 8,
    parameter int EXT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [A_WIDTH-1:0]   base_addr,
    input  logic [A_WIDTH-2:0]   len_words,
    input  logic                 in_valid,
    input  logic [D_WIDTH-1:0]   in_data,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [A_WIDTH-1:0]   mem_addr,
    output logic [EXT_WIDTH-1:0] mem_wd,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           checksum
);

    localparam int LANES = EXT_WIDTH / D_WIDTH;
    localparam int LW    = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t               state, state_nxt;
    logic [LW-1:0]        lane;
    logic [A_WIDTH-2:0]   remaining;
    logic [A_WIDTH-1:0]   addr;
    logic [EXT_WIDTH-1:0] word;
    logic [7:0]           sum;
    logic                 hs;
    logic                 last_lane;

    assign hs        = in_valid & in_ready;
    assign last_lane = (lane == LW'(LANES - 1));

    // Address and word buffer are registers, so the write port is stable
    // for the whole mem_we cycle.
    assign mem_addr = addr;
    assign mem_wd   = word;
    assign checksum = sum;
    assign cpu_hold = busy;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (len_words != '0) ? RECV : DONE;
            end
            RECV: begin
                in_ready = 1'b1;
                if (in_valid && last_lane) state_nxt = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
                // remaining is never 0 here, so "1 left" means this was the last word
                state_nxt = (remaining == (A_WIDTH-1)'(1)) ? DONE : RECV;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane      <= '0;
            remaining <= '0;
            addr      <= '0;
            word      <= '0;
            sum       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    addr      <= base_addr & ~A_WIDTH'(3);
                    remaining <= len_words;
                    sum       <= '0;
                    lane      <= '0;
                end
                RECV: if (hs) begin
                    word[lane*D_WIDTH +: D_WIDTH] <= in_data;
                    lane <= lane + LW'(1);
                    sum  <= sum + 8'(in_data);
                end
                WRITE: begin
                    // wraps naturally at the top of the address space
                    addr      <= addr + A_WIDTH'(4);
                    remaining <= remaining - (A_WIDTH-1)'(1);
                    lane      <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
